apb_completer_ws: RTL
=====================

// Module: apb_completer_ws
// PURPOSE
//  APB completer (slave end) with a DEPTH x DATA_W register file and fixed programmable wait states.
//  Sits behind the master_bridge on the APB bus (PSELx/PENABLE/PWRITE/PADDR/PWDATA in; PRDATA/PREADY/PSLVERR out).
//  Signals PSLVERR for out-of-range addresses.
//  Intended as a drop-in target for slave1/slave2 positions, on PADDR[7:0].
// PARAMETERS
//  ADDR_W    8    address width (PADDR[ADDR_W-1:0])
//  DATA_W    8    data width of PWDATA/PRDATA and storage
//  DEPTH     128  implemented locations; address >= DEPTH is an error
//  WAIT_CYC  2    access-phase cycles with PREADY=0 before completion (0..15)
// PORTS
//  PCLK     in   1       bus clock, all state on rising edge
//  PRESET   in   1       reset, asynchronous, active-high
//  PSEL     in   1       completer select
//  PENABLE  in   1       access-phase indicator
//  PWRITE   in   1       1=write, 0=read
//  PADDR    in   ADDR_W  transfer address
//  PWDATA   in   DATA_W  write data
//  PRDATA   out  DATA_W  read data, valid only while PREADY=1 on a read
//  PREADY   out  1       transfer-complete, registered
//  PSLVERR  out  1       error response, valid only while PREADY=1
//  err_cnt  out  8       saturating error count (only with APB_SLV_ERRCNT_EN)
// BEHAVIOUR
//  Reset (async, PRESET=1):
//   - PREADY=0, PSLVERR=0, PRDATA=0, FSM=IDLE, wait counter=0, all storage=0, err_cnt=0.
//  FSM states IDLE, WAIT, DONE; PREADY, PRDATA and PSLVERR are registered.
//  IDLE: on edge with PSEL=1 & PENABLE=0 (setup phase):
//   - latch PADDR, PWRITE and PWDATA; err = (PADDR >= DEPTH).
//   - WAIT_CYC=0: go DONE; PREADY=1 in the first access cycle (zero-wait).
//   - otherwise load cnt=WAIT_CYC and go WAIT.
//  WAIT: PREADY=0; cnt decrements each edge while PSEL&PENABLE; at cnt==1 go DONE.
//   - exactly WAIT_CYC access cycles with PREADY=0, then 1 cycle with PREADY=1.
//  DONE: PREADY=1, PSLVERR=err.
//   - read, no err: PRDATA=mem[addr].
//   - read with err: PRDATA=0.
//   - on the completing edge (PSEL&PENABLE&PREADY), write with !err: mem[addr]<=latched wdata.
//   - the write commits exactly once; err writes are dropped.
//   - next state IDLE; PREADY, PSLVERR and PRDATA return to 0.
//  Back-to-back: a new setup phase in the cycle after DONE is accepted from IDLE with no bubble.
//  Abort: PSEL=0 while in WAIT or DONE -> IDLE next edge, no write, PREADY=0.
//  PENABLE=1 seen in IDLE without a prior setup is ignored (protocol violation; no response).
//  Address, write flag and data are sampled only at setup; changes during access are ignored.
//  Reset mid-transfer: immediate return to reset values; a pending write is lost.
// CONFIGURATION
//  APB_SLV_ERRCNT_EN defined:
//   - port err_cnt present; increments by 1 on each completed transfer with PSLVERR=1.
//   - err_cnt saturates at 255 and is cleared only by PRESET.
//  APB_SLV_ERRCNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  - Reset: PRESET pulse mid-idle -> PREADY=0, PSLVERR=0, PRDATA=0, read of addr 0x05 returns 0x00.
//  - Write then read, WAIT_CYC=2:
//    - write 0x3C to 0x05 -> PREADY low for 2 access cycles, high on 3rd, PSLVERR=0.
//    - read 0x05 -> PRDATA=0xC3? no: PRDATA=0x3C.
//  - WAIT_CYC=0: write 0xA5 to 0x7F, read back -> each access completes in 1 cycle, PRDATA=0xA5.
//  - Error: write 0x11 to 0x80 (DEPTH=128) -> PSLVERR=1 with PREADY; read 0x80 -> PRDATA=0, PSLVERR=1.
//    - with APB_SLV_ERRCNT_EN: err_cnt=2.
//  - Abort: start write 0x55 to 0x10, drop PSEL in 1st wait cycle -> no PREADY; read 0x10 returns prior value.
//  - Back-to-back writes 0x01->0x00, 0x02->0x01, then reads -> no idle gap needed; reads return 0x01, 0x02.

Source files
------------

// File: rtl/apb_completer_ws.sv
// APB completer with a DEPTH x DATA_W register file, a fixed number of wait states and PSLVERR for out-of-range addresses.
// Optional saturating error counter on port err_cnt, enabled by defining APB_SLV_ERRCNT_EN.
module apb_completer_ws #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 128,
  parameter int WAIT_CYC = 2
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
`ifdef APB_SLV_ERRCNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0] WAIT_L = 4'(WAIT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  addr_reg, addr_next;
  logic              write_reg, write_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              err_reg, err_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic              done_ok;
  logic              commit;

  assign done_ok = (state_reg == S_DONE) && PSEL && PENABLE;
  assign commit  = done_ok && write_reg && !err_reg;
  // Read data is taken for the transfer about to enter DONE, so it uses the next-cycle address.
  assign rd_word = mem[addr_next];

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    write_next = write_reg;
    wdata_next = wdata_reg;
    err_next   = err_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          addr_next  = PADDR[IDX_W-1:0];
          write_next = PWRITE;
          wdata_next = PWDATA;
          err_next   = ({1'b0, PADDR} >= DEPTH_L);
          if (WAIT_L == 4'd0) begin
            state_next = S_DONE;
          end else begin
            cnt_next   = WAIT_L;
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!PSEL) begin
          state_next = S_IDLE;
        end else if (PENABLE) begin
          cnt_next = cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_reg <= S_IDLE;
      addr_reg  <= '0;
      write_reg <= 1'b0;
      wdata_reg <= '0;
      err_reg   <= 1'b0;
      cnt_reg   <= 4'd0;
      PREADY    <= 1'b0;
      PSLVERR   <= 1'b0;
      PRDATA    <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      write_reg <= write_next;
      wdata_reg <= wdata_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
      PREADY    <= (state_next == S_DONE);
      PSLVERR   <= (state_next == S_DONE) && err_next;
      PRDATA    <= ((state_next == S_DONE) && !write_next && !err_next) ? rd_word : '0;
    end
  end

  // Storage must clear on reset, so it is a register file rather than block RAM.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit) begin
      mem[addr_reg] <= wdata_reg;
    end
  end

`ifdef APB_SLV_ERRCNT_EN
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      err_cnt <= 8'd0;
    end else if (done_ok && err_reg && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
